cordic_req_arbiter: RTL and testbench

- Shares one CORDIC_COS_SIN pipeline between NUM_REQ requesters.
- Each cycle, round-robin arbitration picks at most one phase request and drives it into the CORDIC with the fixed gain-compensated x0 and y0=0.
- A tag shift register tracks every issued request through the fixed pipeline latency, so each result returns to the requester that issued it.
- Sits between angle-consuming blocks (NCO, mixers, rotators) and the single CORDIC instance.

---
 rtl/cordic_req_arbiter.sv | 115 +++++++++++
 tb/tb_cordic_req_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_req_arbiter.sv
// Round-robin front end that shares one CORDIC_COS_SIN pipeline among NUM_REQ requesters.
// A tag shift register follows each issue through the pipeline so results return to their issuer.
module cordic_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 32,
    parameter int LATENCY     = 17,
    parameter int X_INIT      = 39797
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PHASE_WIDTH-1:0] req_phase,
    output logic                           cor_en,
    output logic [DATA_WIDTH-1:0]          cor_x0,
    output logic [DATA_WIDTH-1:0]          cor_y0,
    output logic [PHASE_WIDTH-1:0]         cor_phase,
    input  logic                           cor_valid,
    input  logic [DATA_WIDTH:0]            cor_cos,
    input  logic [DATA_WIDTH:0]            cor_sin,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH:0]            rsp_cos,
    output logic [DATA_WIDTH:0]            rsp_sin,
    output logic [$clog2(LATENCY+2)-1:0]   inflight,
    output logic                           err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 2);
    localparam int QW    = $clog2(LATENCY + 1);

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   issue_idx;
    logic [LATENCY-1:0] tag_vld;
    logic [IDX_W-1:0]   tag_idx [LATENCY];
    logic               tail_vld;
    logic [IDX_W-1:0]   tail_idx;
    logic [QW-1:0]      quiet;

    assign cor_x0   = DATA_WIDTH'(X_INIT);
    assign cor_y0   = '0;
    assign tail_vld = tag_vld[LATENCY-1];
    assign tail_idx = tag_idx[LATENCY-1];

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        if (enable && !rst) begin
            for (int unsigned n = 0; n < NUM_REQ; n++) begin
                cand = IDX_W'((32'(ptr) + n) % NUM_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_any) req_ready[grant_idx] = 1'b1;
        end
    end

    // Index half of the tag pipe needs no reset; only the valid bits matter.
    always_ff @(posedge clk) begin
        tag_idx[0] <= issue_idx;
        for (int unsigned i = 1; i < LATENCY; i++) tag_idx[i] <= tag_idx[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cor_en    <= 1'b0;
            cor_phase <= '0;
            issue_idx <= '0;
            tag_vld   <= '0;
            rsp_valid <= '0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
            inflight  <= '0;
            err       <= 1'b0;
            quiet     <= QW'(LATENCY);
        end else begin
            cor_en <= grant_any;
            if (grant_any) begin
                cor_phase <= req_phase[grant_idx*PHASE_WIDTH +: PHASE_WIDTH];
                issue_idx <= grant_idx;
                ptr       <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end

            tag_vld <= {tag_vld[LATENCY-2:0], cor_en};

            rsp_valid <= '0;
            if (cor_valid && tail_vld) begin
                rsp_valid[tail_idx] <= 1'b1;
                rsp_cos             <= cor_cos;
                rsp_sin             <= cor_sin;
            end

            // Results of pre-reset issues may still emerge for LATENCY cycles; don't flag them.
            if ((cor_valid && !tail_vld && quiet == '0) || (tail_vld && !cor_valid)) err <= 1'b1;
            if (quiet != '0) quiet <= quiet - 1'b1;

            case ({grant_any, tail_vld})
                2'b10: if (inflight != CNT_W'(LATENCY + 1)) inflight <= inflight + 1'b1;
                2'b01: if (inflight != '0) inflight <= inflight - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Self-checking bench for cordic_req_arbiter: behavioural CORDIC stand-in plus a
// round-robin / latency scoreboard model, randomized and directed scenarios.
module tb_cordic_req_arbiter;
    localparam int NR = 4, DW = 16, PW = 32, LAT = 17;

    logic clk = 1'b0;
    logic rst, enable;
    logic [NR-1:0] req_valid, req_ready;
    logic [PW-1:0] ph [NR];
    logic [NR*PW-1:0] req_phase;
    logic cor_en;
    logic [DW-1:0] cor_x0, cor_y0;
    logic [PW-1:0] cor_phase;
    logic cor_valid;
    logic [DW:0] cor_cos, cor_sin;
    logic [NR-1:0] rsp_valid;
    logic [DW:0] rsp_cos, rsp_sin;
    logic [4:0] inflight;
    logic err;

    int tests_run = 0, tests_failed = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    int ptr_m = 0;
    logic err_exp = 1'b0;
    logic [DW:0] exp_cos = '0, exp_sin = '0;

    typedef struct { int idx; logic [PW-1:0] phase; int due; } sb_t;
    sb_t sb[$];
    int acc_t[$];

    assign req_phase = {ph[3], ph[2], ph[1], ph[0]};

    cordic_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .LATENCY(LAT), .X_INIT(39797)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
        .req_phase(req_phase), .cor_en(cor_en), .cor_x0(cor_x0), .cor_y0(cor_y0),
        .cor_phase(cor_phase), .cor_valid(cor_valid), .cor_cos(cor_cos), .cor_sin(cor_sin),
        .rsp_valid(rsp_valid), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal cos/sin scaled by 65536: quadrant*90 deg plus signed angle with 16 fractional bits.
    function automatic logic [DW:0] trig(input logic [PW-1:0] p, input logic want_sin);
        real deg, r, v;
        logic [29:0] a;
        a   = p[29:0];
        deg = 90.0 * real'(int'(p[31:30])) + real'($signed(a)) / 65536.0;
        r   = deg * 3.14159265358979 / 180.0;
        v   = (want_sin ? $sin(r) : $cos(r)) * 65536.0;
        if (v > 65535.0) v = 65535.0;
        if (v < -65536.0) v = -65536.0;
        return (DW+1)'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
    endfunction

    // CORDIC stand-in: fixed LATENCY, never reset, with fault injection knobs.
    logic [LAT-1:0] m_v = '0;
    logic [PW-1:0] m_ph [LAT] = '{default: '0};
    logic inject = 1'b0, drop_en = 1'b0;
    always @(posedge clk) begin
        m_v <= {m_v[LAT-2:0], cor_en & ~drop_en};
        m_ph[0] <= cor_phase;
        for (int i = 1; i < LAT; i++) m_ph[i] <= m_ph[i-1];
    end
    assign cor_valid = m_v[LAT-1] | inject;
    assign cor_cos   = trig(m_ph[LAT-1], 1'b0);
    assign cor_sin   = trig(m_ph[LAT-1], 1'b1);

    // Response / inflight / err scoreboard, sampled at negedge each cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [NR-1:0] exp_rv;
            int n_if;
            exp_rv = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_rv[sb[0].idx] = 1'b1;
                exp_cos = trig(sb[0].phase, 1'b0);
                exp_sin = trig(sb[0].phase, 1'b1);
                void'(sb.pop_front());
            end
            tests_run++;
            if (rsp_valid !== exp_rv) begin
                tests_failed++;
                $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
            end
            tests_run++;
            if (rsp_cos !== exp_cos || rsp_sin !== exp_sin) begin
                tests_failed++;
                $display("FAIL rsp_data cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, rsp_cos, rsp_sin, exp_cos, exp_sin);
            end
            n_if = 0;
            foreach (acc_t[i]) if (acc_t[i] < cyc && cyc <= acc_t[i] + LAT + 1) n_if++;
            while (acc_t.size() > 0 && acc_t[0] + LAT + 1 < cyc) void'(acc_t.pop_front());
            tests_run++;
            if (inflight !== 5'(n_if)) begin
                tests_failed++;
                $display("FAIL inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, n_if);
            end
            tests_run++;
            if (err !== err_exp) begin
                tests_failed++;
                $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, err_exp);
            end
        end
    end

    function automatic int model_grant(input logic [NR-1:0] v, input logic en);
        if (!en) return -1;
        for (int n = 0; n < NR; n++) if (v[(ptr_m + n) % NR]) return (ptr_m + n) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        return (g < 0) ? '0 : NR'(1 << g);
    endfunction

    task automatic step(input logic [NR-1:0] v, input logic en);
        @(negedge clk); #1;
        req_valid = v;
        enable    = en;
        #1;
    endtask

    task automatic commit(input int g);
        if (g >= 0) begin
            sb.push_back('{idx: g, phase: ph[g], due: cyc + LAT + 2});
            acc_t.push_back(cyc);
            ptr_m = (g + 1) % NR;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            rst = 1'b1; req_valid = '0; enable = 1'b0;
            sb.delete(); acc_t.delete();
            ptr_m = 0; exp_cos = '0; exp_sin = '0; err_exp = 1'b0;
        end
        @(negedge clk); #1;
        rst = 1'b0; enable = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        tests_run++;
        if (cor_x0 !== 16'd39797 || cor_y0 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_x0y0 got=%0d/%0d exp=39797/0", cor_x0, cor_y0);
        end
        do_reset(2);
        tests_run++;
        if (cor_en !== 1'b0 || cor_phase !== '0 || rsp_valid !== '0 || rsp_cos !== '0 ||
            rsp_sin !== '0 || inflight !== '0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state got en=%b ph=%h rv=%b cos=%0d sin=%0d if=%0d err=%b exp all zero",
                     cor_en, cor_phase, rsp_valid, rsp_cos, rsp_sin, inflight, err);
        end
        mon_on = 1'b1;
    endtask

    task automatic test_single();
        int n0, d;
        step(4'b0100, 1'b1);
        ph[2] = {2'd0, 30'd2949120};
        n0 = cyc;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        commit(model_grant(4'b0100, 1'b1));
        step('0, 1'b1);
        tests_run++;
        if (cor_en !== 1'b1 || cor_phase !== {2'd0, 30'd2949120} || cor_x0 !== 16'd39797 || cor_y0 !== '0) begin
            tests_failed++;
            $display("FAIL single_issue got en=%b ph=%h x0=%0d y0=%0d exp 1/%h/39797/0",
                     cor_en, cor_phase, cor_x0, cor_y0, {2'd0, 30'd2949120});
        end
        for (int k = 0; k < 20; k++) begin
            step('0, 1'b1);
            if (cyc == n0 + 19) begin
                tests_run++;
                if (rsp_valid !== 4'b0100) begin
                    tests_failed++;
                    $display("FAIL single_latency got=%b exp=0100", rsp_valid);
                end
                d = int'($signed(rsp_cos)) - 46341;
                tests_run++;
                if (d < -4 || d > 4 || rsp_sin !== rsp_cos) begin
                    tests_failed++;
                    $display("FAIL single_value got=%0d/%0d exp=46341+-4", rsp_cos, rsp_sin);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int g;
        logic [29:0] a;
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            step(4'hF, 1'b1);
            a = (k < 4) ? 30'd2949120 : 30'(-2949120);
            for (int i = 0; i < NR; i++) ph[i] = {2'(i), a};
            g = model_grant(4'hF, 1'b1);
            tests_run++;
            if (req_ready !== NR'(1 << (k % 4))) begin
                tests_failed++;
                $display("FAIL fair_grant k=%0d got=%b exp=%b", k, req_ready, NR'(1 << (k % 4)));
            end
            commit(g);
        end
        idle(22);
    endtask

    task automatic test_back_to_back();
        int g, peak, cnt, first, last;
        peak = 0; cnt = 0; first = -1; last = -1;
        for (int k = 0; k < 45; k++) begin
            step((k < 20) ? 4'b0010 : 4'b0000, 1'b1);
            ph[1] = $urandom;
            g = model_grant((k < 20) ? 4'b0010 : 4'b0000, 1'b1);
            if (k < 20) begin
                tests_run++;
                if (req_ready !== 4'b0010) begin
                    tests_failed++;
                    $display("FAIL b2b_ready k=%0d got=%b exp=0010", k, req_ready);
                end
            end
            commit(g);
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rsp_valid[1]) begin
                cnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        tests_run++;
        if (cnt != 20 || last - first != 19) begin
            tests_failed++;
            $display("FAIL b2b_pulses got=%0d span=%0d exp=20 span=19", cnt, last - first);
        end
        tests_run++;
        if (peak != 18) begin
            tests_failed++;
            $display("FAIL b2b_peak got=%0d exp=18", peak);
        end
    endtask

    task automatic test_enable();
        int g;
        logic en;
        for (int k = 0; k < 10; k++) begin
            en = !(k >= 3 && k < 7);
            step(4'hF, en);
            for (int i = 0; i < NR; i++) ph[i] = $urandom;
            g = model_grant(4'hF, en);
            tests_run++;
            if (req_ready !== onehot(g)) begin
                tests_failed++;
                $display("FAIL enable_grant k=%0d got=%b exp=%b", k, req_ready, onehot(g));
            end
            commit(g);
        end
        idle(22);
    endtask

    task automatic test_random();
        int g;
        logic [NR-1:0] v;
        logic en;
        for (int k = 0; k < 150; k++) begin
            v  = NR'($urandom_range(0, 15));
            en = ($urandom_range(0, 7) != 0);
            step(v, en);
            for (int i = 0; i < NR; i++) ph[i] = $urandom;
            g = model_grant(v, en);
            tests_run++;
            if (req_ready !== onehot(g)) begin
                tests_failed++;
                $display("FAIL random_grant k=%0d got=%b exp=%b", k, req_ready, onehot(g));
            end
            commit(g);
        end
        idle(22);
    endtask

    task automatic test_reset_midflight();
        int g;
        for (int k = 0; k < 5; k++) begin
            step(4'hF, 1'b1);
            for (int i = 0; i < NR; i++) ph[i] = $urandom;
            g = model_grant(4'hF, 1'b1);
            commit(g);
        end
        do_reset(1);
        tests_run++;
        if (cor_en !== 1'b0 || cor_phase !== '0 || rsp_valid !== '0 || inflight !== '0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_state got en=%b ph=%h rv=%b if=%0d err=%b exp zeros",
                     cor_en, cor_phase, rsp_valid, inflight, err);
        end
        idle(25);
    endtask

    task automatic test_spurious();
        idle(5);
        step('0, 1'b1);
        inject = 1'b1;
        err_exp = 1'b1;
        step('0, 1'b1);
        inject = 1'b0;
        tests_run++;
        if (err !== 1'b1 || rsp_valid !== '0) begin
            tests_failed++;
            $display("FAIL spurious_err got err=%b rv=%b exp 1/0000", err, rsp_valid);
        end
        idle(5);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL spurious_sticky got=%b exp=1", err);
        end
        do_reset(1);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_clear got=%b exp=0", err);
        end
    endtask

    task automatic test_drop();
        int n0;
        step(4'b0001, 1'b1);
        ph[0] = $urandom;
        n0 = cyc;
        commit(model_grant(4'b0001, 1'b1));
        void'(sb.pop_back());
        step('0, 1'b1);
        drop_en = 1'b1;
        step('0, 1'b1);
        drop_en = 1'b0;
        while (cyc < n0 + 18) step('0, 1'b1);
        err_exp = 1'b1;
        idle(4);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL drop_err got=%b exp=1", err);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; req_valid = '0;
        for (int i = 0; i < NR; i++) ph[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_back_to_back();
        test_enable();
        test_random();
        test_reset_midflight();
        test_spurious();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
